// File: rtl/mole_round_controller_if.sv
// Bundles the game-control inputs and the round/score outputs of the mole round controller.
// Latency: none; this is a pure signal bundle.
// Backpressure: none; every signal is a plain level sampled or driven each clk.
interface mole_round_controller_if;
  logic        start;
  logic [17:0] hit_switches;
  logic [17:0] mole_positions;
  logic        mole_clk;
  logic [17:0] active_moles;
  logic [7:0]  score;
  logic [7:0]  misses;
  logic [7:0]  rounds_left;
  logic        game_over;

  // Driver side: the player/board environment.
  modport master (
    output start, hit_switches, mole_positions,
    input  mole_clk, active_moles, score, misses, rounds_left, game_over
  );

  // Controller side.
  modport slave (
    input  start, hit_switches, mole_positions,
    output mole_clk, active_moles, score, misses, rounds_left, game_over
  );
endinterface

// File: rtl/mole_round_controller.sv
// Runs a whack-a-mole game: strobes the mole generator, latches the pattern, scores whacks per round.
// Latency: every output is a register; input effects appear one clk after they are sampled.
// Backpressure: none; start is a level honoured only in IDLE/DONE, switch edges outside RUN are dropped.
module mole_round_controller #(
  parameter int ROUND_CYCLES = 8,
  parameter int GAME_ROUNDS  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  mole_round_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_LATCH,
    S_RUN,
    S_DONE
  } state_t;

  localparam int            CW       = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ROUND_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [17:0]   prev_q;
  logic [17:0]   active_q, active_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    misses_q, misses_d;
  logic [7:0]    rounds_q, rounds_d;
  logic          mole_clk_q, mole_clk_d;
  logic          game_over_q, game_over_d;

  logic [17:0]   edges;
  logic [17:0]   hits;
  logic [17:0]   wrong;
  logic [17:0]   remain;
  logic          last_run;
  logic [4:0]    hit_cnt;
  logic [4:0]    wrong_cnt;
  logic [4:0]    remain_cnt;
  logic [9:0]    score_sum;
  logic [9:0]    miss_sum;

  function automatic logic [4:0] pop18(input logic [17:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 18; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Rising edges are taken against last cycle's switch value, whatever the state.
  assign edges      = bus.hit_switches & ~prev_q;
  assign hits       = edges & active_q;
  assign wrong      = edges & ~active_q;
  assign remain     = active_q & ~edges;
  assign last_run   = (state_q == S_RUN) && (cnt_q == LAST_CNT);
  assign hit_cnt    = pop18(hits);
  assign wrong_cnt  = pop18(wrong);
  assign remain_cnt = pop18(remain);
  // Escapes on the last cycle are counted after that cycle's hits are removed.
  assign score_sum  = {2'b00, score_q} + {5'd0, hit_cnt};
  assign miss_sum   = {2'b00, misses_q} + {5'd0, wrong_cnt}
                    + (last_run ? {5'd0, remain_cnt} : 10'd0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection: start only matters in IDLE/DONE, rounds end after ROUND_CYCLES of RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_PULSE;
      S_PULSE:        state_d = S_LATCH;
      S_LATCH:        state_d = S_RUN;
      S_RUN:          if (last_run) state_d = (rounds_q <= 8'd1) ? S_DONE : S_PULSE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and the round counter.
  always_comb begin
    active_d    = active_q;
    score_d     = score_q;
    misses_d    = misses_q;
    rounds_d    = rounds_q;
    cnt_d       = cnt_q;
    mole_clk_d  = (state_d == S_PULSE);
    game_over_d = (state_d == S_DONE);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          active_d = '0;
          score_d  = '0;
          misses_d = '0;
          rounds_d = 8'(GAME_ROUNDS);
        end
      end
      S_LATCH: begin
        active_d = bus.mole_positions;
        cnt_d    = '0;
      end
      S_RUN: begin
        active_d = remain;
        score_d  = (score_sum > 10'd255) ? 8'hFF : score_sum[7:0];
        misses_d = (miss_sum > 10'd255) ? 8'hFF : miss_sum[7:0];
        cnt_d    = cnt_q + CW'(1);
        if (last_run) begin
          cnt_d    = '0;
          rounds_d = rounds_q - 8'd1;
          // The final round leaves no moles up.
          if (rounds_q <= 8'd1) active_d = '0;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Output and datapath registers, all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      prev_q      <= '0;
      active_q    <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      rounds_q    <= '0;
      mole_clk_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prev_q      <= bus.hit_switches;
      active_q    <= active_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      rounds_q    <= rounds_d;
      mole_clk_q  <= mole_clk_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.mole_clk     = mole_clk_q;
  assign bus.active_moles = active_q;
  assign bus.score        = score_q;
  assign bus.misses       = misses_q;
  assign bus.rounds_left  = rounds_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_mole_round_controller.sv
// Self-checking bench for mole_round_controller with a round-level scoring model.
// Latency: inputs driven and outputs sampled on the falling clk edge.
// Backpressure: none; every task is a fixed-length cycle sequence.
module tb_mole_round_controller;
  localparam int RC = 8;
  localparam int GR = 3;

  logic clk = 1'b0;
  logic reset;

  mole_round_controller_if bus ();

  mole_round_controller #(
    .ROUND_CYCLES(RC),
    .GAME_ROUNDS (GR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Game-level model: totals, rounds still to play, the set of moles still up.
  int          m_score;
  int          m_misses;
  int          m_rounds;
  logic [17:0] m_active;
  logic        m_over;
  logic [17:0] last_sw;

  logic [42:0] dut_vec;
  assign dut_vec = {bus.active_moles, bus.score, bus.misses, bus.rounds_left, bus.game_over};

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [42:0] exp_vec();
    return {m_active, 8'(m_score), 8'(m_misses), 8'(m_rounds), m_over};
  endfunction

  // One clk with the given switch value; reports which switches rose this cycle.
  task automatic tick(input logic [17:0] sw, output logic [17:0] e);
    bus.hit_switches = sw;
    @(posedge clk);
    @(negedge clk);
    e       = sw & ~last_sw;
    last_sw = sw;
  endtask

  // One RUN cycle: whacks on up moles score, others are wrong; leftovers escape at round end.
  task automatic run_cycle(input logic [17:0] sw, input bit last);
    logic [17:0] e;
    tick(sw, e);
    m_score  = sat(m_score + $countones(e & m_active));
    m_misses = sat(m_misses + $countones(e & ~m_active));
    m_active = m_active & ~e;
    if (last) begin
      m_misses = sat(m_misses + $countones(m_active));
      m_rounds = m_rounds - 1;
      if (m_rounds == 0) begin
        m_active = '0;
        m_over   = 1'b1;
      end
    end
  endtask

  // From IDLE/DONE: request a game; afterwards the strobe cycle is visible.
  task automatic do_start(input logic [17:0] pattern);
    logic [17:0] e;
    bus.start          = 1'b1;
    bus.mole_positions = pattern;
    tick(last_sw, e);
    bus.start = 1'b0;
    m_score   = 0;
    m_misses  = 0;
    m_rounds  = GR;
    m_active  = '0;
    m_over    = 1'b0;
  endtask

  // From the strobe cycle: pass the latch cycle; afterwards RUN cycle 0 is in progress.
  task automatic enter_round(input logic [17:0] pattern, input logic [17:0] sw);
    logic [17:0] e;
    bus.mole_positions = pattern;
    tick(sw, e);
    tick(sw, e);
    m_active = pattern;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.hit_switches   = '0;
    bus.mole_positions = '0;
    last_sw            = '0;
    m_score = 0; m_misses = 0; m_rounds = 0; m_active = '0; m_over = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== 43'd0 || bus.mole_clk !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %h mole_clk=%b expected all zero", dut_vec, bus.mole_clk);
    end
    reset = 1'b0;
    repeat (4) tick(18'h0, e);
    checks++;
    if (dut_vec !== exp_vec() || bus.mole_clk !== 1'b0) begin
      failures++;
      $display("FAIL reset_stays_idle: got %h mole_clk=%b expected %h mole_clk=0", dut_vec, bus.mole_clk, exp_vec());
    end
  endtask

  task automatic test_start();
    logic [17:0] e;
    do_start(18'h00005);
    checks++;
    if (bus.mole_clk !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse: mole_clk got %b expected 1", bus.mole_clk);
    end
    checks++;
    if (dut_vec !== exp_vec() || bus.rounds_left !== 8'd3) begin
      failures++;
      $display("FAIL start_state: got %h expected %h", dut_vec, exp_vec());
    end
    tick(18'h0, e);
    checks++;
    if (bus.mole_clk !== 1'b0) begin
      failures++;
      $display("FAIL start_pulse_width: mole_clk got %b expected 0", bus.mole_clk);
    end
    tick(18'h0, e);
    m_active = 18'h00005;
    checks++;
    if (bus.active_moles !== 18'h00005 || bus.rounds_left !== 8'd3 || bus.mole_clk !== 1'b0) begin
      failures++;
      $display("FAIL start_latch: active got %h rounds %0d expected 00005 rounds 3", bus.active_moles, bus.rounds_left);
    end
  endtask

  task automatic test_dual_hit();
    for (int k = 0; k < RC - 1; k++) run_cycle(18'h0, 1'b0);
    checks++;
    if (dut_vec !== exp_vec() || bus.active_moles !== 18'h00005) begin
      failures++;
      $display("FAIL dual_before: got %h expected %h", dut_vec, exp_vec());
    end
    run_cycle(18'h00005, 1'b1);
    checks++;
    if (bus.score !== 8'd2 || bus.misses !== 8'd0 || bus.rounds_left !== 8'd2) begin
      failures++;
      $display("FAIL dual_hit: got score=%0d misses=%0d rounds=%0d expected 2 0 2", bus.score, bus.misses, bus.rounds_left);
    end
    checks++;
    if (bus.mole_clk !== 1'b1 || bus.game_over !== 1'b0) begin
      failures++;
      $display("FAIL dual_next_round: mole_clk=%b game_over=%b expected 1 0", bus.mole_clk, bus.game_over);
    end
  endtask

  task automatic test_hit_wrong();
    enter_round(18'h00005, 18'h0);
    run_cycle(18'h00001, 1'b0);
    checks++;
    if (bus.active_moles !== 18'h00004 || bus.score !== 8'd3 || bus.misses !== 8'd0) begin
      failures++;
      $display("FAIL hit: got active=%h score=%0d misses=%0d expected 00004 3 0", bus.active_moles, bus.score, bus.misses);
    end
    run_cycle(18'h00003, 1'b0);
    checks++;
    if (bus.active_moles !== 18'h00004 || bus.score !== 8'd3 || bus.misses !== 8'd1) begin
      failures++;
      $display("FAIL wrong_whack: got active=%h score=%0d misses=%0d expected 00004 3 1", bus.active_moles, bus.score, bus.misses);
    end
    for (int k = 2; k < RC; k++) run_cycle(18'h00003, k == RC - 1);
    checks++;
    if (dut_vec !== exp_vec() || bus.misses !== 8'd2 || bus.rounds_left !== 8'd1) begin
      failures++;
      $display("FAIL hit_round_end: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_escaped();
    enter_round(18'h30001, 18'h0);
    for (int k = 0; k < RC; k++) run_cycle(18'h0, k == RC - 1);
    checks++;
    if (bus.misses !== 8'd5 || bus.score !== 8'd3) begin
      failures++;
      $display("FAIL escaped: got misses=%0d score=%0d expected 5 3", bus.misses, bus.score);
    end
    checks++;
    if (bus.game_over !== 1'b1 || bus.active_moles !== 18'h0 || bus.rounds_left !== 8'd0) begin
      failures++;
      $display("FAIL game_end: got over=%b active=%h rounds=%0d expected 1 0 0", bus.game_over, bus.active_moles, bus.rounds_left);
    end
  endtask

  task automatic test_game_end_restart();
    logic [17:0] e;
    for (int k = 0; k < 4; k++) begin
      tick(18'($urandom) | 18'h00001 << k, e);
      checks++;
      if (dut_vec !== exp_vec() || bus.mole_clk !== 1'b0) begin
        failures++;
        $display("FAIL done_ignores_edges: got %h mole_clk=%b expected %h mole_clk=0", dut_vec, bus.mole_clk, exp_vec());
      end
    end
    do_start(18'h0002A);
    checks++;
    if ({bus.score, bus.misses, bus.rounds_left, bus.game_over} !== {8'd0, 8'd0, 8'd3, 1'b0} || bus.mole_clk !== 1'b1) begin
      failures++;
      $display("FAIL restart: got score=%0d misses=%0d rounds=%0d over=%b mole_clk=%b", bus.score, bus.misses, bus.rounds_left, bus.game_over, bus.mole_clk);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [17:0] e;
    enter_round(18'h00003, 18'h0);
    run_cycle(18'h0, 1'b0);
    run_cycle(18'h0, 1'b0);
    bus.hit_switches = 18'h00001;
    #2 reset = 1'b1;
    #1;
    m_score = 0; m_misses = 0; m_rounds = 0; m_active = '0; m_over = 1'b0;
    checks++;
    if (dut_vec !== 43'd0 || bus.mole_clk !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got %h mole_clk=%b expected all zero", dut_vec, bus.mole_clk);
    end
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    last_sw = '0;
    repeat (3) tick(18'h00001, e);
    checks++;
    if (dut_vec !== exp_vec() || bus.mole_clk !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got %h mole_clk=%b expected %h mole_clk=0", dut_vec, bus.mole_clk, exp_vec());
    end
    do_start(18'h00001);
    enter_round(18'h00001, 18'h00001);
    for (int k = 0; k < RC; k++) run_cycle(18'h00001, k == RC - 1);
    checks++;
    if (bus.score !== 8'd0 || bus.misses !== 8'd1 || bus.rounds_left !== 8'd2) begin
      failures++;
      $display("FAIL held_switch: got score=%0d misses=%0d rounds=%0d expected 0 1 2", bus.score, bus.misses, bus.rounds_left);
    end
  endtask

  task automatic test_random();
    logic [17:0] sw;
    for (int g = 0; g < 3; g++) begin
      if (g > 0) do_start(18'($urandom));
      while (!m_over) begin
        enter_round(18'($urandom), last_sw);
        for (int k = 0; k < RC; k++) begin
          sw = last_sw ^ (18'($urandom) & 18'($urandom) & 18'($urandom));
          run_cycle(sw, k == RC - 1);
          checks++;
          if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL random_state g%0d k%0d: got %h expected %h", g, k, dut_vec, exp_vec());
          end
          checks++;
          if (bus.mole_clk !== 1'((k == RC - 1) && !m_over)) begin
            failures++;
            $display("FAIL random_mole_clk g%0d k%0d: got %b", g, k, bus.mole_clk);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_dual_hit();
    test_hit_wrong();
    test_escaped();
    test_game_end_restart();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
